// File: rtl/cwc_capture_ctrl.sv
// Capture sequencer for the logic-analyzer sample RAM.
// It fills a circular pre-trigger window, takes the qualified trigger, records
// the post-trigger window, then reads the whole buffer back oldest-first.
// All RAM address and enable generation lives here; RAM data is handled elsewhere.
module cwc_capture_ctrl #(
    parameter int RAM_DATA_DEPTH = 4096,
    parameter int ADDR_W         = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              abort,
    input  logic [ADDR_W-1:0] pre_trig_len,
    input  logic              sample_en,
    input  logic              trig,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    input  logic              rd_start,
    input  logic              rd_next,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_raddr,
    output logic              rd_valid,
    output logic              rd_last,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [2:0]        state_o,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRE       = 3'd1,
        S_WAIT_TRIG = 3'd2,
        S_POST      = 3'd3,
        S_DONE      = 3'd4,
        S_READ      = 3'd5
    } state_t;

    // Addresses and counters are reduced modulo the RAM depth with this mask.
    localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(RAM_DATA_DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
    logic [ADDR_W-1:0] p_len_q, p_len_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              ram_re_q, ram_re_d;
    logic              last_pend_q, last_pend_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;

    logic [ADDR_W-1:0] p_clamped;
    logic [ADDR_W-1:0] q_len;
    logic [ADDR_W-1:0] waddr_inc;
    logic [ADDR_W-1:0] pre_cnt_inc;
    logic [ADDR_W-1:0] post_cnt_inc;
    logic              capturing;
    logic              start_cap;

    assign p_clamped    = (pre_trig_len > ADDR_MASK) ? ADDR_MASK : pre_trig_len;
    assign q_len        = ADDR_MASK - p_len_q;
    assign waddr_inc    = (waddr_q + ONE) & ADDR_MASK;
    assign pre_cnt_inc  = pre_cnt_q + ONE;
    assign post_cnt_inc = post_cnt_q + ONE;
    assign capturing    = (state_q == S_PRE) || (state_q == S_WAIT_TRIG) || (state_q == S_POST);
    // Arm is honoured only from IDLE or DONE, and abort always beats it.
    assign start_cap    = arm && !abort && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Next-state, counter and read-pipeline logic.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        state_d     = state_q;
        waddr_d     = waddr_q;
        pre_cnt_d   = pre_cnt_q;
        post_cnt_d  = post_cnt_q;
        p_len_d     = p_len_q;
        trig_addr_d = trig_addr_q;
        base_d      = base_q;
        idx_d       = idx_q;
        raddr_d     = raddr_q;
        ram_re_d    = 1'b0;
        last_pend_d = 1'b0;
        rd_valid_d  = ram_re;
        rd_last_d   = ram_re && last_pend_q;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_PRE: begin
                    if (sample_en) begin
                        waddr_d   = waddr_inc;
                        pre_cnt_d = pre_cnt_inc;
                        if (pre_cnt_inc == p_len_q) state_d = S_WAIT_TRIG;
                    end
                end
                S_WAIT_TRIG: begin
                    if (sample_en) begin
                        waddr_d = waddr_inc;
                        if (trig) begin
                            trig_addr_d = waddr_q;
                            state_d     = (q_len != '0) ? S_POST : S_DONE;
                        end
                    end
                end
                S_POST: begin
                    if (sample_en) begin
                        waddr_d    = waddr_inc;
                        post_cnt_d = post_cnt_inc;
                        if (post_cnt_inc == q_len) state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (rd_start && !arm) begin
                        state_d = S_READ;
                        idx_d   = '0;
                        base_d  = (trig_addr_q - p_len_q) & ADDR_MASK;
                    end
                end
                S_READ: begin
                    if (rd_next) begin
                        ram_re_d    = 1'b1;
                        raddr_d     = (base_q + idx_q) & ADDR_MASK;
                        last_pend_d = (idx_q == ADDR_MASK);
                        idx_d       = (idx_q + ONE) & ADDR_MASK;
                        if (idx_q == ADDR_MASK) state_d = S_IDLE;
                    end
                end
                default: ;
            endcase
        end

        // Shared arm path for IDLE and DONE (re-arm).
        if (start_cap) begin
            waddr_d    = '0;
            pre_cnt_d  = '0;
            post_cnt_d = '0;
            p_len_d    = p_clamped;
            state_d    = (p_clamped != '0) ? S_PRE : S_WAIT_TRIG;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            state_q     <= S_IDLE;
            waddr_q     <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            p_len_q     <= '0;
            trig_addr_q <= '0;
            base_q      <= '0;
            idx_q       <= '0;
            raddr_q     <= '0;
            ram_re_q    <= 1'b0;
            last_pend_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            waddr_q     <= waddr_d;
            pre_cnt_q   <= pre_cnt_d;
            post_cnt_q  <= post_cnt_d;
            p_len_q     <= p_len_d;
            trig_addr_q <= trig_addr_d;
            base_q      <= base_d;
            idx_q       <= idx_d;
            raddr_q     <= raddr_d;
            ram_re_q    <= ram_re_d;
            last_pend_q <= last_pend_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
        end
    end

    // Abort kills both RAM enables in the same cycle it is seen.
    assign ram_we    = capturing && sample_en && !abort;
    assign ram_re    = ram_re_q && !abort;
    assign ram_waddr = waddr_q;
    assign ram_raddr = raddr_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign trig_addr = trig_addr_q;
    assign state_o   = state_q;
    assign busy      = capturing || (state_q == S_READ);

endmodule

// File: tb/tb_cwc_capture_ctrl.sv
// Bench for cwc_capture_ctrl at DEPTH=16. Expected behaviour comes from a
// sample-count view of a capture: write k lands at k mod 16, the trigger is the
// first qualified trig at or after sample P, and the capture ends Q samples later.
module tb_cwc_capture_ctrl;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst, arm, abort, sample_en, trig, rd_start, rd_next;
    logic [AW-1:0] pre_trig_len;
    logic          ram_we, ram_re, rd_valid, rd_last, busy;
    logic [AW-1:0] ram_waddr, ram_raddr, trig_addr;
    logic [2:0]    state_o;

    int n_pass  = 0;
    int n_total = 0;

    cwc_capture_ctrl #(.RAM_DATA_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .arm(arm), .abort(abort), .pre_trig_len(pre_trig_len),
        .sample_en(sample_en), .trig(trig), .ram_we(ram_we), .ram_waddr(ram_waddr),
        .rd_start(rd_start), .rd_next(rd_next), .ram_re(ram_re), .ram_raddr(ram_raddr),
        .rd_valid(rd_valid), .rd_last(rd_last), .trig_addr(trig_addr),
        .state_o(state_o), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    endtask

    // Outputs are observed mid-cycle; inputs change just after the rising edge.
    task automatic sample();
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    function automatic int wrap(input int v);
        return ((v % DEPTH) + DEPTH) % DEPTH;
    endfunction

    // mode 0: random qualifier/trigger; mode 1: trig only on unqualified cycles
    // for the first 40 cycles, then on qualified ones; mode 2: sample_en=1 and
    // trig raised when the stored-sample count equals trig_n.
    task automatic run_capture(input int p_req, input int mode, input int trig_n,
                               input bit with_rd_start, output int trig_pos);
        int p, q, n, tidx, cyc;
        bit en, tg;
        p    = (p_req > DEPTH - 1) ? DEPTH - 1 : p_req;
        q    = DEPTH - 1 - p;
        n    = 0;
        tidx = -1;
        cyc  = 0;
        pre_trig_len = AW'(p_req);
        arm      = 1'b1;
        rd_start = with_rd_start;
        sample();
        chk("arm_we", 32'(ram_we), 32'(0));
        advance();
        arm      = 1'b0;
        rd_start = 1'b0;
        while (!(tidx >= 0 && n == tidx + 1 + q) && cyc < 400) begin
            case (mode)
                0: begin
                    en = ($urandom_range(0, 3) != 0);
                    tg = ($urandom_range(0, 7) == 0);
                end
                1: begin
                    en = (cyc % 2 == 0);
                    tg = (cyc < 40) ? !en : en;
                end
                default: begin
                    en = 1'b1;
                    tg = (n == trig_n);
                end
            endcase
            sample_en = en;
            trig      = tg;
            sample();
            chk("cap_state", 32'(state_o), (n < p) ? 32'(1) : (tidx < 0) ? 32'(2) : 32'(3));
            chk("cap_busy", 32'(busy), 32'(1));
            chk("cap_we", 32'(ram_we), 32'(en));
            if (en) chk("cap_waddr", 32'(ram_waddr), 32'(wrap(n)));
            if (mode == 1 && cyc == 40) chk("qual_no_trig", 32'(tidx < 0), 32'(1));
            if (en) begin
                if (tg && tidx < 0 && n >= p) tidx = n;
                n++;
            end
            advance();
            cyc++;
        end
        trig      = 1'b0;
        sample_en = 1'b1;
        sample();
        chk("cap_complete", 32'(tidx >= 0 && n == tidx + 1 + q), 32'(1));
        chk("done_state", 32'(state_o), 32'(4));
        chk("done_busy", 32'(busy), 32'(0));
        chk("done_we", 32'(ram_we), 32'(0));
        chk("trig_addr", 32'(trig_addr), 32'(wrap(tidx)));
        advance();
        sample_en = 1'b0;
        trig_pos  = tidx;
    endtask

    // Readout of the whole buffer from `base`, either back-to-back or with random gaps.
    task automatic run_read(input int base, input bit b2b, input bit arm_mid);
        int issued, re_cnt, valid_cnt, cyc;
        bit nx, prev_nx, prev2_nx;
        issued    = 0;
        re_cnt    = 0;
        valid_cnt = 0;
        cyc       = 0;
        prev_nx   = 1'b0;
        prev2_nx  = 1'b0;
        rd_start  = 1'b1;
        sample();
        chk("rd_start_state", 32'(state_o), 32'(4));
        advance();
        rd_start = 1'b0;
        while (valid_cnt < DEPTH && cyc < 200) begin
            nx      = (issued < DEPTH) && (b2b || ($urandom_range(0, 1) == 1));
            rd_next = nx;
            arm     = arm_mid && (cyc == 5);
            sample();
            chk("rd_state", 32'(state_o), (issued < DEPTH) ? 32'(5) : 32'(0));
            chk("rd_re", 32'(ram_re), 32'(prev_nx));
            if (prev_nx) begin
                chk("rd_raddr", 32'(ram_raddr), 32'(wrap(base + re_cnt)));
                re_cnt++;
            end
            chk("rd_valid", 32'(rd_valid), 32'(prev2_nx));
            chk("rd_last", 32'(rd_last), 32'(prev2_nx && valid_cnt == DEPTH - 1));
            if (prev2_nx) valid_cnt++;
            if (nx) issued++;
            prev2_nx = prev_nx;
            prev_nx  = nx;
            advance();
            cyc++;
        end
        rd_next = 1'b0;
        arm     = 1'b0;
        chk("rd_words", 32'(valid_cnt), 32'(DEPTH));
    endtask

    initial begin
        int t, p;
        rst = 1'b1; arm = 1'b0; abort = 1'b0; sample_en = 1'b0; trig = 1'b0;
        rd_start = 1'b0; rd_next = 1'b0; pre_trig_len = '0;
        advance();
        advance();
        sample();
        chk("rst_state", 32'(state_o), 32'(0));
        chk("rst_outs", {ram_we, ram_re, rd_valid, rd_last, busy}, 32'(0));
        chk("rst_addrs", {ram_waddr, ram_raddr, trig_addr}, 32'(0));
        advance();
        rst = 1'b0;

        // Basic window: P=4, trigger on the 7th stored sample.
        run_capture(4, 2, 6, 1'b0, t);
        chk("basic_trig", 32'(t), 32'(6));
        run_read(wrap(t - 4), 1'b0, 1'b0);

        // No pre-trigger window.
        run_capture(0, 2, 0, 1'b0, t);
        run_read(wrap(t - 0), 1'b0, 1'b0);

        // Largest pre window: trigger write goes straight to DONE.
        run_capture(15, 2, 15, 1'b0, t);
        chk("maxp_trig", 32'(t), 32'(15));
        run_read(wrap(t - 15), 1'b0, 1'b0);

        // Qualifier test, arm+rd_start in DONE (arm wins), then back-to-back read with an ignored arm.
        run_capture(2, 1, -1, 1'b0, t);
        run_capture(2, 1, -1, 1'b1, t);
        run_read(wrap(t - 2), 1'b1, 1'b1);

        // Abort in POST after 3 post writes.
        pre_trig_len = AW'(2);
        arm = 1'b1;
        advance();
        arm = 1'b0;
        sample_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            trig = (i == 2);
            advance();
        end
        trig  = 1'b0;
        abort = 1'b1;
        sample();
        chk("abort_we", 32'(ram_we), 32'(0));
        chk("abort_in_post", 32'(state_o), 32'(3));
        advance();
        abort     = 1'b0;
        sample_en = 1'b0;
        sample();
        chk("abort_state", 32'(state_o), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_trig_held", 32'(trig_addr), 32'(2));
        advance();

        // Re-arm after abort, then random captures and reads.
        run_capture(5, 0, -1, 1'b0, t);
        run_read(wrap(t - 5), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            p = int'($urandom_range(0, DEPTH - 1));
            run_capture(p, 0, -1, 1'b0, t);
            run_read(wrap(t - p), bit'($urandom_range(0, 1)), 1'b0);
        end

        // Reset from DONE clears everything including trig_addr.
        run_capture(3, 2, 9, 1'b0, t);
        rst = 1'b1;
        advance();
        sample();
        chk("midrst_state", 32'(state_o), 32'(0));
        chk("midrst_trig", 32'(trig_addr), 32'(0));
        rst = 1'b0;
        advance();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
